lfsr_sequencer: RTL and testbench
=================================

Name: lfsr_sequencer

Overview:
- Drives the LFSR pulse/readout controller automatically for a host-programmed number of iterations.
- Each iteration:
  - issue a pulse trigger;
  - complete the integration handshake on sw_integ with a programmable high time;
  - wait for the pulse sequence to retire;
  - optionally issue a shift/readout trigger and wait out its fixed duration.
- Sits between the host wire/trigger endpoints and the LFSR controller, on the same fabric clock.

Parameters:
- TIMEOUT_CYC, 4096, max cycles waiting for integ_trig or for inf_mode_off to fall before error.
- SHIFT_GUARD, 20, extra cycles added to the computed shift/readout duration.

Ports:
- clk  in  1  fabric clock, shared with LFSR controller.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle; begins a run when IDLE.
- stop  in  1  single-cycle; graceful stop at end of current iteration.
- num_iter  in  8  iterations per run; sampled at start.
- integ_width  in  8  sw_integ high cycles; sampled at start; 0 treated as 1.
- do_shift  in  1  enable readout after each pulse; sampled at start.
- shift_cycle  in  9  readout shift length; sampled at start; 0 disables readout.
- integ_trig  in  1  from controller: ready for integration.
- inf_mode_off  in  1  from controller: high for the whole pulse sequence.
- lfsr_pulse_trigger  out  1  one-cycle pulse to controller.
- lfsr_shift_trigger  out  1  one-cycle pulse to controller.
- sw_integ  out  1  integration handshake to controller.
- busy  out  1  high from the cycle after start until DONE/ERR.
- done  out  1  one-cycle pulse at run completion.
- stopped  out  1  sticky; run ended by stop; cleared on start.
- err  out  1  sticky; timeout; cleared on start.
- iter_count  out  8  completed iterations in current/last run.

Behaviour:
- Reset: all outputs 0; state IDLE; latched config 0.
- All outputs registered. Triggers are exactly one cycle wide and are never asserted together.
- States and transitions:
  - IDLE: start → latch config, clear err/stopped/iter_count → CHECK. start while not IDLE is ignored.
  - CHECK: iter_count==num_iter or stop_pending → DONE; otherwise → PULSE_REQ. num_iter==0 gives done 2 cycles after start, with no trigger.
  - PULSE_REQ: assert lfsr_pulse_trigger for 1 cycle; clear timer → WAIT_INTEG.
  - WAIT_INTEG: integ_trig==1 → INTEG_HI, sw_integ=1 from next cycle. Timer reaching TIMEOUT_CYC → ERR.
  - INTEG_HI: hold sw_integ=1 for max(integ_width,1) cycles, then sw_integ=0 → WAIT_RETIRE.
  - WAIT_RETIRE: inf_mode_off==0 → SHIFT_REQ if readout is enabled, else NEXT. Timeout → ERR.
  - SHIFT_REQ: assert lfsr_shift_trigger for 1 cycle; load down-counter = 2*shift_cycle + 16 + SHIFT_GUARD (11-bit) → SHIFT_WAIT.
  - SHIFT_WAIT: counter reaches 0 → NEXT.
  - NEXT: iter_count+1 → CHECK.
  - DONE: done=1 for 1 cycle; busy=0 → IDLE.
  - ERR: err=1, busy=0, sw_integ=0 → IDLE next cycle. err stays latched.
- stop: sets stop_pending in any non-IDLE state; honoured only in CHECK, which then sets stopped=1. The integ handshake is therefore never abandoned half-way, so the controller cannot be stranded. stop in IDLE is ignored.
- start and stop in the same cycle in IDLE: run starts with stop_pending set. Result: done after 2 cycles, stopped=1, iter_count=0.
- Timer is 13-bit saturating and is cleared on every state entry.
- iter_count wraps never (bounded by num_iter ≤ 255).
- Reset mid-run: immediate IDLE, outputs 0. The host must also reset the controller.

Decomposition:
- Shared package holds:
  - state encoding (4-bit localparams);
  - the constant 16 (readout words per shift);
  - default TIMEOUT_CYC and SHIFT_GUARD.
- One sub-module is natural: seq_timer, a loadable down-counter/up-timer with zero and timeout flags, reused for WAIT_* timeouts and SHIFT_WAIT.

Test Plan:
- Basic run: num_iter=3, integ_width=5, do_shift=0; model asserts integ_trig 6 cycles after each trigger and drops inf_mode_off 4 cycles after sw_integ falls → 3 pulse triggers, each sw_integ high exactly 5 cycles, done once, iter_count=3.
- Readout: num_iter=2, do_shift=1, shift_cycle=256 → shift trigger after each retire; next pulse trigger exactly 2*256+16+20+2 cycles later.
- num_iter=0, and separately integ_width=0 → done 2 cycles after start with no triggers; sw_integ high 1 cycle per iteration respectively.
- Timeout: integ_trig never asserted → err=1 at TIMEOUT_CYC+1 cycles after trigger; busy=0; sw_integ=0; no done.
- stop asserted during INTEG_HI of iteration 2 of 5 → handshake completes, stopped=1, iter_count=2, done pulses.
- rst_n pulsed low mid SHIFT_WAIT → all outputs 0 asynchronously; next start runs normally from iter_count=0.

Source files
------------

// File: rtl/lfsr_sequencer_pkg.sv
// Shared types and constants for the LFSR pulse/readout sequencer.
// State encoding, latched run configuration and the readout duration helper.
package lfsr_sequencer_pkg;

  localparam int unsigned ITER_W          = 8;
  localparam int unsigned WIDTH_W         = 8;
  localparam int unsigned SHIFT_W         = 9;
  localparam int unsigned TIMER_W         = 13;
  localparam int unsigned SHIFT_CNT_W     = 11;
  localparam int unsigned WORDS_PER_SHIFT = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned DEF_SHIFT_GUARD = 20;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CHECK       = 4'd1,
    ST_PULSE_REQ   = 4'd2,
    ST_WAIT_INTEG  = 4'd3,
    ST_INTEG_HI    = 4'd4,
    ST_WAIT_RETIRE = 4'd5,
    ST_SHIFT_REQ   = 4'd6,
    ST_SHIFT_WAIT  = 4'd7,
    ST_NEXT        = 4'd8,
    ST_DONE        = 4'd9,
    ST_ERR         = 4'd10
  } seq_state_e;

  // Run configuration captured when a run starts.
  typedef struct packed {
    logic [ITER_W-1:0]  num_iter;
    logic [WIDTH_W-1:0] integ_width;
    logic               shift_en;
    logic [SHIFT_W-1:0] shift_cycle;
  } seq_cfg_t;

  // Readout duration: two cycles per shift bit, one per readout word, plus guard.
  function automatic logic [SHIFT_CNT_W-1:0] shift_wait_len(
    input logic [SHIFT_W-1:0] shift_cycle,
    input int unsigned        guard
  );
    return SHIFT_CNT_W'({shift_cycle, 1'b0})
         + SHIFT_CNT_W'(WORDS_PER_SHIFT)
         + SHIFT_CNT_W'(guard);
  endfunction

endpackage

// File: rtl/lfsr_sequencer_timer.sv
// seq_timer: saturating up-timer with timeout flag, or loadable down-counter.
// load wins over clr; dec selects down-counting, otherwise it counts up.
module seq_timer
  import lfsr_sequencer_pkg::*;
#(
  parameter int unsigned W     = TIMER_W,
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         timeout_c,
  output logic         last_c
);

  localparam logic [W-1:0] CNT_MAX    = '1;
  localparam logic [W-1:0] TIMEOUT_M1 = W'(LIMIT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clr) begin
      count <= '0;
    end else if (dec) begin
      if (count != '0) count <= count - W'(1);
    end else if (count != CNT_MAX) begin
      count <= count + W'(1);
    end
  end

  // timeout_c: the count reaches LIMIT on this edge.
  assign timeout_c = (count >= TIMEOUT_M1);
  // last_c: a down-count reaches zero on this edge.
  assign last_c    = (count == W'(1));

endmodule

// File: rtl/lfsr_sequencer.sv
// Iterates pulse trigger, integration handshake, retire wait and optional
// readout against the LFSR controller for a host-programmed number of runs.
module lfsr_sequencer
  import lfsr_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned SHIFT_GUARD = DEF_SHIFT_GUARD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [ITER_W-1:0]  num_iter,
  input  logic [WIDTH_W-1:0] integ_width,
  input  logic               do_shift,
  input  logic [SHIFT_W-1:0] shift_cycle,
  input  logic               integ_trig,
  input  logic               inf_mode_off,
  output logic               lfsr_pulse_trigger,
  output logic               lfsr_shift_trigger,
  output logic               sw_integ,
  output logic               busy,
  output logic               done,
  output logic               stopped,
  output logic               err,
  output logic [ITER_W-1:0]  iter_count
);

  seq_state_e           state;
  seq_state_e           state_d;
  seq_cfg_t             cfg_q;
  logic                 stop_pending;
  logic                 start_run;

  logic                 tmr_clr;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic [TIMER_W-1:0]   tmr_load_val;
  logic [TIMER_W-1:0]   tmr_count;
  logic                 tmr_timeout_c;
  logic                 tmr_last_c;

  assign start_run    = (state == ST_IDLE) && start;
  assign tmr_load_val = TIMER_W'(shift_wait_len(cfg_q.shift_cycle, SHIFT_GUARD));

  seq_timer #(
    .W     (TIMER_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .dec       (tmr_dec),
    .count     (tmr_count),
    .timeout_c (tmr_timeout_c),
    .last_c    (tmr_last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state and timer control.
  always_comb begin
    state_d  = state;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (stop_pending || (iter_count == cfg_q.num_iter)) state_d = ST_DONE;
        else                                                state_d = ST_PULSE_REQ;
      end
      ST_PULSE_REQ: begin
        state_d = ST_WAIT_INTEG;
      end
      ST_WAIT_INTEG: begin
        if (integ_trig)         state_d = ST_INTEG_HI;
        else if (tmr_timeout_c) state_d = ST_ERR;
      end
      ST_INTEG_HI: begin
        if ((tmr_count + TIMER_W'(1)) == TIMER_W'(cfg_q.integ_width)) state_d = ST_WAIT_RETIRE;
      end
      ST_WAIT_RETIRE: begin
        if (!inf_mode_off)      state_d = cfg_q.shift_en ? ST_SHIFT_REQ : ST_NEXT;
        else if (tmr_timeout_c) state_d = ST_ERR;
      end
      ST_SHIFT_REQ: begin
        state_d = ST_SHIFT_WAIT;
      end
      ST_SHIFT_WAIT: begin
        if (tmr_last_c) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = ST_CHECK;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The readout countdown starts in the trigger cycle and runs on through
    // SHIFT_WAIT, so the next pulse trigger lands exactly duration+2 later.
    tmr_load = (state_d == ST_SHIFT_REQ) && (state != ST_SHIFT_REQ);
    tmr_clr  = (state_d != state) && (state_d != ST_SHIFT_WAIT);
    tmr_dec  = (state == ST_SHIFT_REQ) || (state == ST_SHIFT_WAIT);
  end

  // Registered per-state outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_pulse_trigger <= 1'b0;
      lfsr_shift_trigger <= 1'b0;
      sw_integ           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      lfsr_pulse_trigger <= (state_d == ST_PULSE_REQ);
      lfsr_shift_trigger <= (state_d == ST_SHIFT_REQ);
      sw_integ           <= (state_d == ST_INTEG_HI);
      busy               <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
      done               <= (state_d == ST_DONE);
    end
  end

  // Run configuration, sticky status and iteration count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q        <= '0;
      stop_pending <= 1'b0;
      stopped      <= 1'b0;
      err          <= 1'b0;
      iter_count   <= '0;
    end else if (start_run) begin
      cfg_q.num_iter    <= num_iter;
      cfg_q.integ_width <= (integ_width == '0) ? WIDTH_W'(1) : integ_width;
      cfg_q.shift_en    <= do_shift && (shift_cycle != '0);
      cfg_q.shift_cycle <= shift_cycle;
      stop_pending      <= stop;
      stopped           <= 1'b0;
      err               <= 1'b0;
      iter_count        <= '0;
    end else begin
      if ((state != ST_IDLE) && stop)         stop_pending <= 1'b1;
      if ((state == ST_CHECK) && stop_pending) stopped     <= 1'b1;
      if (state == ST_NEXT)                   iter_count   <= iter_count + ITER_W'(1);
      if (state_d == ST_ERR)                  err          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Self-checking bench: a reactive LFSR-controller model plus a timeline model
// that predicts every trigger, handshake and completion cycle of a run.
module tb_lfsr_sequencer;

  localparam int TIMEOUT = 4096;
  localparam int GUARD   = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, do_shift, integ_trig, inf_mode_off;
  logic [7:0] num_iter, integ_width;
  logic [8:0] shift_cycle;
  logic       lfsr_pulse_trigger, lfsr_shift_trigger, sw_integ;
  logic       busy, done, stopped, err;
  logic [7:0] iter_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int integ_dly = 6;
  int retire_dly = 4;
  bit integ_en = 1'b1;
  bit mid_start = 1'b0;

  lfsr_sequencer #(
    .TIMEOUT_CYC (TIMEOUT),
    .SHIFT_GUARD (GUARD)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .num_iter           (num_iter),
    .integ_width        (integ_width),
    .do_shift           (do_shift),
    .shift_cycle        (shift_cycle),
    .integ_trig         (integ_trig),
    .inf_mode_off       (inf_mode_off),
    .lfsr_pulse_trigger (lfsr_pulse_trigger),
    .lfsr_shift_trigger (lfsr_shift_trigger),
    .sw_integ           (sw_integ),
    .busy               (busy),
    .done               (done),
    .stopped            (stopped),
    .err                (err),
    .iter_count         (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: integ_trig integ_dly cycles after a pulse trigger,
  // inf_mode_off high from the trigger until retire_dly cycles after sw_integ falls.
  int a_cnt, b_cnt;
  bit sw_seen;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_trig   <= 1'b0;
      inf_mode_off <= 1'b0;
      a_cnt        <= 0;
      b_cnt        <= 0;
      sw_seen      <= 1'b0;
    end else begin
      if (a_cnt > 0) begin
        a_cnt <= a_cnt - 1;
        if (a_cnt == 1 && integ_en) integ_trig <= 1'b1;
      end
      if (b_cnt > 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) inf_mode_off <= 1'b0;
      end
      if (lfsr_pulse_trigger) begin
        inf_mode_off <= 1'b1;
        a_cnt        <= integ_dly;
      end
      if (sw_integ) integ_trig <= 1'b0;
      if (sw_seen && !sw_integ) b_cnt <= retire_dly;
      sw_seen <= sw_integ;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One run: predict the timeline, drive start, record events, compare.
  // stop_iter: 0 none, -1 stop together with start, k>0 stop in iteration k's handshake.
  task automatic run(input string tag, input int n, input int w, input int en,
                     input int sc, input int stop_iter);
    int c0, p, weff, d, n_eff, budget, cur_w, done_cyc, err_cyc, both;
    int fin_busy, fin_sw, fin_iter, fin_stopped, fin_err, exp_stopped;
    int exp_pulse[$], exp_shift[$], exp_rise[$];
    int got_pulse[$], got_shift[$], got_rise[$], got_wid[$];
    bit fin, sw_prev, stop_sent, shen;

    weff  = (w == 0) ? 1 : w;
    d     = 2 * sc + 16 + GUARD;
    shen  = (en != 0) && (sc != 0);
    n_eff = n;
    if (stop_iter < 0) n_eff = 0;
    else if (stop_iter > 0 && stop_iter < n) n_eff = stop_iter;
    exp_stopped = (integ_en && (stop_iter < 0 || (stop_iter > 0 && stop_iter < n))) ? 1 : 0;

    @(negedge clk);
    num_iter    = 8'(n);
    integ_width = 8'(w);
    do_shift    = 1'(en);
    shift_cycle = 9'(sc);
    start       = 1'b1;
    stop        = (stop_iter < 0);
    c0          = cyc;

    p = c0 + 2;
    if (integ_en) begin
      for (int k = 0; k < n_eff; k++) begin
        exp_pulse.push_back(p);
        exp_rise.push_back(p + integ_dly + 1);
        if (shen) exp_shift.push_back(p + integ_dly + weff + retire_dly + 2);
        p = p + integ_dly + weff + retire_dly + 4 + (shen ? d : 0);
      end
    end else begin
      exp_pulse.push_back(p);
      p = p + TIMEOUT + 1;
    end
    budget = p - c0 + 64;

    fin = 0; sw_prev = 0; stop_sent = 0; cur_w = 0; both = 0;
    done_cyc = -1; err_cyc = -1;
    fin_busy = 0; fin_sw = 0; fin_iter = 0; fin_stopped = 0; fin_err = 0;
    while (!fin && budget > 0) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      budget--;
      if (lfsr_pulse_trigger) got_pulse.push_back(cyc);
      if (lfsr_shift_trigger) got_shift.push_back(cyc);
      if (lfsr_pulse_trigger && lfsr_shift_trigger) both++;
      if (sw_integ && !sw_prev) got_rise.push_back(cyc);
      if (sw_integ) cur_w++;
      if (!sw_integ && sw_prev) begin got_wid.push_back(cur_w); cur_w = 0; end
      sw_prev = sw_integ;
      if (done || err) begin
        fin = 1;
        if (done) done_cyc = cyc;
        if (err)  err_cyc  = cyc;
        fin_busy = int'(busy); fin_sw = int'(sw_integ); fin_iter = int'(iter_count);
        fin_stopped = int'(stopped); fin_err = int'(err);
      end
      if (stop_iter > 0 && sw_integ && got_rise.size() == stop_iter && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1;
      end
      if (mid_start && sw_integ && got_rise.size() == 1) start = 1'b1;
    end

    chk($sformatf("%s finished", tag), int'(fin), 1);
    chk($sformatf("%s pulse_count", tag), got_pulse.size(), exp_pulse.size());
    for (int i = 0; i < got_pulse.size() && i < exp_pulse.size(); i++)
      chk($sformatf("%s pulse%0d_cycle", tag, i), got_pulse[i] - c0, exp_pulse[i] - c0);
    chk($sformatf("%s shift_count", tag), got_shift.size(), exp_shift.size());
    for (int i = 0; i < got_shift.size() && i < exp_shift.size(); i++)
      chk($sformatf("%s shift%0d_cycle", tag, i), got_shift[i] - c0, exp_shift[i] - c0);
    chk($sformatf("%s integ_count", tag), got_rise.size(), exp_rise.size());
    for (int i = 0; i < got_rise.size() && i < exp_rise.size(); i++)
      chk($sformatf("%s integ%0d_rise", tag, i), got_rise[i] - c0, exp_rise[i] - c0);
    for (int i = 0; i < got_wid.size(); i++)
      chk($sformatf("%s integ%0d_width", tag, i), got_wid[i], weff);
    chk($sformatf("%s triggers_overlap", tag), both, 0);
    if (integ_en) begin
      chk($sformatf("%s done_cycle", tag), done_cyc - c0, p - c0);
      chk($sformatf("%s err_seen", tag), int'(err_cyc >= 0), 0);
    end else begin
      chk($sformatf("%s err_cycle", tag), err_cyc - c0, p - c0);
      chk($sformatf("%s done_seen", tag), int'(done_cyc >= 0), 0);
    end
    chk($sformatf("%s iter_count", tag), fin_iter, integ_en ? n_eff : 0);
    chk($sformatf("%s stopped", tag), fin_stopped, exp_stopped);
    chk($sformatf("%s err", tag), fin_err, integ_en ? 0 : 1);
    chk($sformatf("%s busy_at_end", tag), fin_busy, 0);
    chk($sformatf("%s sw_integ_at_end", tag), fin_sw, 0);
    @(negedge clk);
    chk($sformatf("%s done_one_cycle", tag), int'(done), 0);
    chk($sformatf("%s idle_busy", tag), int'(busy), 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; do_shift = 1'b0;
    num_iter = '0; integ_width = '0; shift_cycle = '0;
    repeat (3) @(negedge clk);
    chk("reset pulse_trig", int'(lfsr_pulse_trigger), 0);
    chk("reset shift_trig", int'(lfsr_shift_trigger), 0);
    chk("reset sw_integ", int'(sw_integ), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset stopped", int'(stopped), 0);
    chk("reset err", int'(err), 0);
    chk("reset iter_count", int'(iter_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stop while idle must not leak into the next run.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_stop busy", int'(busy), 0);

    integ_dly = 6; retire_dly = 4;
    run("basic", 3, 5, 0, 0, 0);
    run("readout", 2, 5, 1, 256, 0);
    run("zero_iter", 0, 5, 0, 0, 0);
    run("zero_width", 2, 0, 0, 0, 0);
    run("shift_len0", 2, 3, 1, 0, 0);
    run("start_stop", 4, 3, 0, 0, -1);
    mid_start = 1'b1;
    run("stop_iter2", 5, 5, 0, 0, 2);
    mid_start = 1'b0;

    for (int r = 0; r < 4; r++) begin
      integ_dly  = int'($urandom_range(1, 8));
      retire_dly = int'($urandom_range(1, 6));
      run($sformatf("rand%0d", r), int'($urandom_range(1, 4)), int'($urandom_range(0, 10)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 60)), 0);
    end

    integ_en = 1'b0;
    run("timeout", 2, 3, 0, 0, 0);
    integ_en = 1'b1;

    // Reset during the second readout wait.
    integ_dly = 6; retire_dly = 4;
    @(negedge clk);
    num_iter = 8'd3; integ_width = 8'd4; do_shift = 1'b1; shift_cycle = 9'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 5000 && seen < 2; i++) begin
      @(negedge clk);
      if (lfsr_shift_trigger) seen++;
    end
    chk("rst_mid shift_seen", seen, 2);
    repeat (10) @(negedge clk);
    chk("rst_mid busy_before", int'(busy), 1);
    chk("rst_mid iter_before", int'(iter_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid iter_count", int'(iter_count), 0);
    chk("rst_mid sw_integ", int'(sw_integ), 0);
    chk("rst_mid triggers", int'(lfsr_pulse_trigger) + int'(lfsr_shift_trigger), 0);
    chk("rst_mid flags", int'(done) + int'(err) + int'(stopped), 0);
    @(negedge clk);
    rst_n = 1'b1;
    integ_dly = 3; retire_dly = 2;
    run("post_reset", 2, 3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
